// File: rtl/flash_loader_pkg.sv
// Shared types and constants for the SPI flash to cache boot loader.
package flash_loader_pkg;

   typedef enum logic [2:0] {
      POWER_WAIT,
      IDLE,
      SEND,
      READ,
      WRITE_REQ,
      WRITE_WAIT,
      DONE
   } state_t;

   localparam logic [7:0]  SPI_CMD_READ = 8'h03;
   localparam logic [31:0] WORD_BYTES   = 32'd4;

endpackage

// File: rtl/flash_loader_if.sv
// Cache write-port bundle between the loader and the cache.
interface flash_loader_if;

   logic [31:0] cache_address;
   logic [31:0] cache_data_in;
   logic [3:0]  cache_write_enable;
   logic        cache_busy;

   modport master (
      output cache_address,
      output cache_data_in,
      output cache_write_enable,
      input  cache_busy
   );

   modport slave (
      input  cache_address,
      input  cache_data_in,
      input  cache_write_enable,
      output cache_busy
   );

endinterface

// File: rtl/flash_loader_spi_bit_engine.sv
// Two-cycle SPI mode-0 bit sequencer: 32-bit shift-out, 8-bit shift-in.
// Idle (bit count 0) holds flash_clk where it is, which pauses the bus.
module flash_loader_spi_bit_engine (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_tx_load,
   input  logic [31:0] i_tx_data,
   input  logic        i_rx_load,
   input  logic        i_stop,
   input  logic        i_miso,
   output logic        o_sclk,
   output logic        o_mosi,
   output logic        o_done,
   output logic [7:0]  o_rx_byte
);

   logic [31:0] r_shift;
   logic [7:0]  r_rx;
   logic [5:0]  r_bits;
   logic        r_high;
   logic        r_sclk;
   logic        r_mosi;
   logic        w_active;

   assign w_active  = (r_bits != 6'd0);
   assign o_done    = w_active && r_high && (r_bits == 6'd1);
   assign o_rx_byte = {r_rx[6:0], i_miso};
   assign o_sclk    = r_sclk;
   assign o_mosi    = r_mosi;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift <= '0;
         r_rx    <= '0;
         r_bits  <= '0;
         r_high  <= 1'b0;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
      end else begin
         if (w_active) begin
            if (!r_high) begin
               r_sclk <= 1'b0;
               r_mosi <= r_shift[31];
               r_high <= 1'b1;
            end else begin
               r_sclk  <= 1'b1;
               r_rx    <= o_rx_byte;
               r_shift <= {r_shift[30:0], 1'b0};
               r_bits  <= r_bits - 6'd1;
               r_high  <= 1'b0;
            end
         end
         if (i_tx_load) begin
            r_shift <= i_tx_data;
            r_bits  <= 6'd32;
            r_high  <= 1'b0;
         end
         // Reload on the last high phase so the next byte follows seamlessly
         if (i_rx_load) begin
            r_shift <= '0;
            r_bits  <= 6'd8;
            r_high  <= 1'b0;
         end
         if (i_stop) begin
            r_sclk <= 1'b0;
            r_mosi <= 1'b0;
            r_bits <= '0;
         end
      end
   end

endmodule

// File: rtl/flash_loader.sv
// Boot copy of an SPI flash region into the cache, one word per write.
// Control FSM and counters; bit timing lives in the SPI engine.
module flash_loader #(
   parameter int unsigned STARTUP_WAIT_CYCLES = 1_000_000,
   parameter logic [23:0] FLASH_START_ADDRESS = 24'h00_0000,
   parameter logic [31:0] CACHE_START_ADDRESS = 32'h0000_0000,
   parameter logic [31:0] TRANSFER_BYTES      = 32'h0010_0000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_start,
   output logic           o_busy,
   output logic           o_done,
   output logic           o_flash_clk,
   output logic           o_flash_mosi,
   input  logic           i_flash_miso,
   output logic           o_flash_cs,
   flash_loader_if.master bus
);

   import flash_loader_pkg::*;

   state_t      r_state;
   logic [31:0] r_cnt;
   logic [31:0] r_bytes;
   logic [31:0] r_word;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_we;
   logic [1:0]  r_lane;
   logic        r_busy;
   logic        r_done;
   logic        r_cs;

   logic        w_start_ok;
   logic        w_more;
   logic        w_bit_done;
   logic        w_rx_load;
   logic        w_stop;
   logic [7:0]  w_rx_byte;

   assign w_start_ok = i_start && (r_state == IDLE || r_state == DONE);
   assign w_more     = (r_bytes != TRANSFER_BYTES);
   assign w_rx_load  = (r_state == SEND && w_bit_done)
                    || (r_state == READ && w_bit_done && r_lane != 2'd3)
                    || (r_state == WRITE_WAIT && !bus.cache_busy && w_more);
   assign w_stop     = r_state == WRITE_WAIT && !bus.cache_busy && !w_more;

   flash_loader_spi_bit_engine u_spi (
      .clk       (clk),
      .rst       (rst),
      .i_tx_load (w_start_ok),
      .i_tx_data ({SPI_CMD_READ, FLASH_START_ADDRESS}),
      .i_rx_load (w_rx_load),
      .i_stop    (w_stop),
      .i_miso    (i_flash_miso),
      .o_sclk    (o_flash_clk),
      .o_mosi    (o_flash_mosi),
      .o_done    (w_bit_done),
      .o_rx_byte (w_rx_byte)
   );

   assign o_busy                 = r_busy;
   assign o_done                 = r_done;
   assign o_flash_cs             = r_cs;
   assign bus.cache_address      = r_addr;
   assign bus.cache_data_in      = r_wdata;
   assign bus.cache_write_enable = r_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= POWER_WAIT;
         r_cnt   <= '0;
         r_bytes <= '0;
         r_word  <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_we    <= '0;
         r_lane  <= '0;
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
         r_cs    <= 1'b1;
      end else begin
         unique case (r_state)
            POWER_WAIT: begin
               if (r_cnt == STARTUP_WAIT_CYCLES - 1) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            IDLE, DONE: begin
               if (i_start) begin
                  r_cs    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_bytes <= '0;
                  r_lane  <= '0;
                  r_state <= SEND;
               end
            end
            SEND: begin
               if (w_bit_done) begin
                  r_lane  <= '0;
                  r_state <= READ;
               end
            end
            READ: begin
               // First flash byte of each word lands in the low lane
               if (w_bit_done) begin
                  r_word[{r_lane, 3'b000} +: 8] <= w_rx_byte;
                  r_lane <= r_lane + 2'd1;
                  if (r_lane == 2'd3) r_state <= WRITE_REQ;
               end
            end
            WRITE_REQ: begin
               if (!bus.cache_busy) begin
                  r_addr  <= CACHE_START_ADDRESS + r_bytes;
                  r_wdata <= r_word;
                  r_we    <= 4'b1111;
                  r_bytes <= r_bytes + WORD_BYTES;
                  r_state <= WRITE_WAIT;
               end
            end
            WRITE_WAIT: begin
               if (!bus.cache_busy) begin
                  r_we <= 4'b0000;
                  if (w_more) begin
                     r_state <= READ;
                  end else begin
                     r_cs    <= 1'b1;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end
            default: r_state <= POWER_WAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_loader.sv
// Randomized bench: flash/cache models drive the loader, scoreboard checks writes.
module tb_flash_loader;

   localparam int unsigned WAIT   = 4;
   localparam logic [23:0] FSTART = 24'h12_3456;
   localparam logic [31:0] CSTART = 32'h0000_0000;
   localparam int          NBYTES = 8;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic busy;
   logic done;
   logic flash_clk;
   logic flash_mosi;
   logic flash_miso;
   logic flash_cs;

   flash_loader_if bus ();

   flash_loader #(
      .STARTUP_WAIT_CYCLES (WAIT),
      .FLASH_START_ADDRESS (FSTART),
      .CACHE_START_ADDRESS (CSTART),
      .TRANSFER_BYTES      (NBYTES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (start),
      .o_busy       (busy),
      .o_done       (done),
      .o_flash_clk  (flash_clk),
      .o_flash_mosi (flash_mosi),
      .i_flash_miso (flash_miso),
      .o_flash_cs   (flash_cs),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   int checks = 0;
   int failures = 0;
   wr_t exp_q[$];
   logic [7:0] fbytes [NBYTES];
   logic [7:0] vec [NBYTES] = '{8'h33, 8'h32, 8'h31, 8'h34,
                                8'h0a, 8'h61, 8'h62, 8'h63};

   int   rises = 0;
   int   last_rises = 0;
   int   bad_rises = 0;
   int   stall_left = 0;
   bit   stall_mode = 1'b0;
   bit   rand_busy = 1'b0;
   logic [31:0] cmd = '0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: word w is flash bytes 4w..4w+3, little-endian, at CSTART+4w
   task automatic push_expected();
      for (int w = 0; w < NBYTES / 4; w++) begin
         wr_t e;
         e.addr = CSTART + 32'(4 * w);
         e.data = {fbytes[4*w+3], fbytes[4*w+2], fbytes[4*w+1], fbytes[4*w]};
         exp_q.push_back(e);
      end
   endtask

   // Flash and cache-busy models
   initial begin
      logic prev_sclk;
      logic prev_cs;
      logic moved;
      int   d;
      prev_sclk = 1'b0;
      prev_cs = 1'b1;
      flash_miso = 1'b0;
      bus.cache_busy = 1'b0;
      forever begin
         @(negedge clk);
         moved = (flash_clk !== prev_sclk);
         if (stall_left > 0)
            check("stall_quiet",
                  32'({moved, bus.cache_write_enable != 4'h0}), 0);
         if (flash_cs === 1'b1) begin
            if (prev_cs === 1'b0) last_rises = rises;
            rises = 0;
            if (flash_clk === 1'b1 && prev_sclk === 1'b0) bad_rises++;
         end else if (flash_clk === 1'b1 && prev_sclk === 1'b0) begin
            if (rises < 32) cmd = {cmd[30:0], flash_mosi};
            rises++;
            if (rises == 32) check("cmd_addr", cmd, {8'h03, FSTART});
            if (stall_mode && rises > 32 && (rises - 32) % 32 == 0)
               stall_left = 20;
         end else if (flash_clk === 1'b0 && prev_sclk === 1'b1 && rises >= 32) begin
            d = rises - 32;
            if (d / 8 < NBYTES) flash_miso = fbytes[d/8][7 - d%8];
            else flash_miso = 1'b1;
         end
         prev_sclk = flash_clk;
         prev_cs = flash_cs;
         if (stall_left > 0) begin
            bus.cache_busy = 1'b1;
            stall_left--;
         end else begin
            bus.cache_busy = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
         end
      end
   end

   // Scoreboard monitor
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         #1;
         check("we_lanes", 32'(bus.cache_write_enable == 4'h0 ||
                               bus.cache_write_enable == 4'hF), 1);
         if (bus.cache_write_enable == 4'hF && bus.cache_busy == 1'b0) begin
            if (exp_q.size() == 0) begin
               check("wr_unexpected", 32'(exp_q.size()), 1);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", bus.cache_address, e.addr);
               check("wr_data", bus.cache_data_in, e.data);
            end
         end
      end
   end

   task automatic kick();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("kick_done", 32'(done), 0);
      check("kick_busy", 32'(busy), 1);
      check("kick_cs", 32'(flash_cs), 0);
   endtask

   task automatic run_copy(string name, bit pulses, bit mid_reset);
      int n;
      bit sp;
      bit wp;
      bit rs;
      bit hold;
      n = 0;
      sp = 1'b0;
      wp = 1'b0;
      rs = 1'b0;
      hold = 1'b0;
      while (done !== 1'b1 && n < 6000) begin
         @(negedge clk);
         n++;
         if (hold && flash_cs === 1'b0) hold = 1'b0;
         start = hold;
         if (pulses && !sp && flash_cs === 1'b0 && rises > 4 && rises < 28) begin
            start = 1'b1;
            sp = 1'b1;
         end else if (pulses && !wp && bus.cache_write_enable == 4'hF) begin
            start = 1'b1;
            wp = 1'b1;
         end
         if (mid_reset && !rs && flash_cs === 1'b0 && rises >= 84) begin
            rst = 1'b1;
            rs = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rst_cs", 32'(flash_cs), 1);
            check("rst_we", 32'(bus.cache_write_enable), 0);
            check("rst_busy", 32'(busy), 1);
            check("rst_done", 32'(done), 0);
            check("rst_sclk", 32'(flash_clk), 0);
            exp_q.delete();
            push_expected();
            hold = 1'b1;
            start = 1'b1;
         end
      end
      start = 1'b0;
      check({name, "_timeout"}, 32'(done), 1);
   endtask

   task automatic check_end(string name);
      @(negedge clk);
      #2;
      check({name, "_done"}, 32'(done), 1);
      check({name, "_busy"}, 32'(busy), 0);
      check({name, "_cs"}, 32'(flash_cs), 1);
      check({name, "_sclk"}, 32'(flash_clk), 0);
      check({name, "_pending"}, 32'(exp_q.size()), 0);
      check({name, "_bits"}, 32'(last_rises), 32 + 8 * NBYTES);
      check({name, "_cs_rise"}, 32'(bad_rises), 0);
   endtask

   task automatic randomize_flash();
      for (int i = 0; i < NBYTES; i++) fbytes[i] = 8'($urandom);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b1;
      for (int i = 0; i < NBYTES; i++) fbytes[i] = vec[i];
      push_expected();
      repeat (3) @(negedge clk);
      check("rst_busy0", 32'(busy), 1);
      check("rst_done0", 32'(done), 0);
      check("rst_cs0", 32'(flash_cs), 1);
      check("rst_sclk0", 32'(flash_clk), 0);
      check("rst_mosi0", 32'(flash_mosi), 0);
      check("rst_addr0", bus.cache_address, 0);
      check("rst_data0", bus.cache_data_in, 0);
      check("rst_we0", 32'(bus.cache_write_enable), 0);
      rst = 1'b0;
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         check("pw_busy", 32'(busy), 1);
         check("pw_cs", 32'(flash_cs), 1);
      end
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);
      check("idle_cs", 32'(flash_cs), 1);
      @(negedge clk);
      check("go_cs", 32'(flash_cs), 0);
      check("go_busy", 32'(busy), 1);
      start = 1'b0;
      run_copy("run1", 1'b0, 1'b0);
      check_end("run1");

      push_expected();
      kick();
      run_copy("run2", 1'b1, 1'b0);
      check_end("run2");

      randomize_flash();
      stall_mode = 1'b1;
      push_expected();
      kick();
      run_copy("run3", 1'b0, 1'b0);
      check_end("run3");
      stall_mode = 1'b0;

      randomize_flash();
      rand_busy = 1'b1;
      push_expected();
      kick();
      run_copy("run4", 1'b0, 1'b1);
      check_end("run4");

      for (int k = 0; k < 3; k++) begin
         randomize_flash();
         push_expected();
         kick();
         run_copy("runr", 1'b1, 1'b0);
         check_end("runr");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: got no finish expected finish before 90000 cycles");
      $fatal(1);
   end

endmodule
